uart_rx: RTL

Serial receiver that sits directly downstream of the team's `uart_tx` and consumes its line output. It recovers 8N1 frames: start bit low, 8 data bits LSB first, one stop bit high. Received bytes are presented on a one-entry valid/ready output register. Framing and overrun events are reported as single-cycle pulses. With `CLKS_PER_BIT=1`, the block decodes the one-bit-per-clock stream that `uart_tx` produces, back to back.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the receiver state encoding
//   DATA_BITS  : payload bits per frame
//   IDLE_LEVEL : line level between frames (also used by uart_tx)
//   rx_state_t : receiver FSM states
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for the serial line
//   clk : clock
//   rst : synchronous active-high reset, both flops load the idle line level
//   d   : asynchronous line input
//   q   : synchronised line, two cycles behind d
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Resetting to the idle level keeps the receiver from seeing a false
   // start bit while the synchroniser refills after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= IDLE_LEVEL;
         q    <= IDLE_LEVEL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with a one-entry valid/ready output
//   CLKS_PER_BIT : clocks per bit period, 1..255
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   rx           : serial line, idle high
//   data         : received byte, meaningful while valid=1
//   valid        : byte held in the output register
//   ready        : consumer takes the byte when valid && ready
//   busy         : high in every state except IDLE
//   frame_err    : one-cycle pulse, stop bit sampled low
//   overrun      : one-cycle pulse, completed byte dropped because output was full
// Build option: define UART_RX_SYNC_EN to pass rx through uart_sync2
// (adds two cycles of latency); otherwise rx is used directly.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 busy,
   output logic                 frame_err,
   output logic                 overrun
);

   // HALF is the offset from the detected falling edge to mid-bit.
   localparam int             HALF     = (CLKS_PER_BIT - 1) / 2;
   localparam logic [7:0]     HALF_CNT = 8'(HALF);
   localparam logic [7:0]     LAST_CNT = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );
`else
   assign rx_s = rx;
`endif

   rx_state_t            state, state_n;
   logic [7:0]           clk_cnt, clk_cnt_n;
   logic [2:0]           bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 byte_done;
   logic                 stop_bad;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WAIT_HIGH;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         clk_cnt <= clk_cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
      end
   end

   always_comb begin
      state_n   = state;
      clk_cnt_n = clk_cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      byte_done = 1'b0;
      stop_bad  = 1'b0;

      case (state)
         // Only a high line re-arms start detection, so a line stuck low
         // after a framing error cannot retrigger reception.
         WAIT_HIGH: begin
            clk_cnt_n = '0;
            if (rx_s == IDLE_LEVEL) begin
               state_n = IDLE;
            end
         end

         IDLE: begin
            clk_cnt_n = '0;
            if (rx_s != IDLE_LEVEL) begin
               bit_idx_n = '0;
               // With HALF=0 the detection cycle is already mid-bit.
               if (HALF == 0) begin
                  state_n   = DATA;
                  clk_cnt_n = '0;
               end else begin
                  state_n   = START;
                  clk_cnt_n = 8'd1;
               end
            end
         end

         START: begin
            if (clk_cnt == HALF_CNT) begin
               clk_cnt_n = '0;
               if (rx_s != IDLE_LEVEL) begin
                  state_n = DATA;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               clk_cnt_n = clk_cnt + 8'd1;
            end
         end

         DATA: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_n        = '0;
               shreg_n[bit_idx] = rx_s;
               if (bit_idx == LAST_BIT) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               clk_cnt_n = clk_cnt + 8'd1;
            end
         end

         STOP: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_n = '0;
               if (rx_s == IDLE_LEVEL) begin
                  byte_done = 1'b1;
                  state_n   = IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_n   = WAIT_HIGH;
               end
            end else begin
               clk_cnt_n = clk_cnt + 8'd1;
            end
         end

         default: begin
            state_n   = WAIT_HIGH;
            clk_cnt_n = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Output holding register. A completing byte may load in the same cycle
   // that the consumer takes the previous one; otherwise it is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (byte_done) begin
            if (!valid || ready) begin
               data  <= shreg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule
